mesi_isc_breq_arb: RTL and testbench
====================================

// Module: mesi_isc_breq_arb
// PURPOSE
//  Main-bus broadcast request arbiter for the MESI ISC. Sits directly downstream of the four CPU
//  main-bus ports driven by the CPU BFM, where mbus_cmd/mbus_addr are driven and mbus_ack is consumed.
//  Round-robin selects one broadcast request per cycle, acks the winning CPU and queues
//  {id,cmd,addr} for the coherence-broadcast stage that drives cbus_cmd*/cbus_addr.
// PARAMETERS
//  ADDR_WIDTH      32  main-bus address width (from mesi_isc_pkg)
//  MBUS_CMD_WIDTH  3   main-bus command width (from mesi_isc_pkg)
//  FIFO_DEPTH      4   request queue entries; power of 2, >=2
// PORTS
//  clk             in   1                  system clock, all state on posedge
//  rst             in   1                  synchronous, active-high reset
//  mbus_cmd_i      in   [3:0][MBUS_CMD_WIDTH] per-CPU main-bus command
//  mbus_addr_i     in   [3:0][ADDR_WIDTH]  per-CPU main-bus address
//  mbus_ack_o      out  4                  per-CPU accept pulse, one-hot or zero
//  breq_valid_o    out  1                  queue head valid
//  breq_ready_i    in   1                  broadcast stage pops head when valid&ready
//  breq_id_o       out  2                  head source CPU
//  breq_cmd_o      out  MBUS_CMD_WIDTH     head command (WR_BROAD/RD_BROAD only)
//  breq_addr_o     out  ADDR_WIDTH         head address
//  fifo_count_o    out  $clog2(FIFO_DEPTH)+1 occupancy
//  err_o           out  1                  sticky: illegal command code seen
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): mbus_ack_o=0, breq_valid_o=0, fifo_count_o=0, err_o=0,
//    rr_ptr=3 so CPU0 has top priority first. Outputs breq_id/cmd/addr_o = 0 when empty.
//  - Reset mid-operation flushes queue and drops any ack in flight. Partial requests are not kept.
//  - Eligible CPU i in cycle t: mbus_cmd_i[i] in {WR_BROAD(3), RD_BROAD(4)} AND mbus_ack_o[i]==0
//    (masks a master in its own ack cycle while it still holds the cmd) AND fifo not full.
//  - NOP(0), WR(1), RD(2) are never acked here. Codes 5-7 are ignored and set err_o until reset.
//  - Grant: first eligible CPU searching rr_ptr+1, rr_ptr+2, ... mod 4. On grant at posedge end of
//    t: mbus_ack_o[g]<=1 for exactly cycle t+1; push {g,cmd,addr}; rr_ptr<=g.
//  - No grant: ack all 0, rr_ptr holds.
//  - Ack latency: 1 cycle from request visible to ack. Queue head is visible in t+1 if empty
//    (show-ahead); a pop needs valid&ready at posedge.
//  - Full (count==FIFO_DEPTH): no grant that cycle, even if a pop happens in the same cycle.
//    Requester keeps cmd asserted and waits.
//  - Empty: breq_valid_o=0; ready ignored; no underflow.
//  - Simultaneous push and pop: count unchanged, order strictly FIFO, pointers wrap mod FIFO_DEPTH.
//  - Requester protocol: hold cmd/addr stable until ack; drop cmd to NOP in the cycle after ack.
//    A re-asserted request after that is a new transaction.
// STRUCTURE
//  - mesi_isc_pkg: MBUS_CMD_NOP/WR/RD/WR_BROAD/RD_BROAD constants, ADDR_WIDTH, MBUS_CMD_WIDTH,
//    typedef struct packed {logic [1:0] id; logic [MBUS_CMD_WIDTH-1:0] cmd;
//    logic [ADDR_WIDTH-1:0] addr;} breq_entry_t.
//  - Sub-module mesi_isc_breq_fifo: synchronous show-ahead FIFO of breq_entry_t.
//    push/pop/full/empty/count; wr/rd pointers with extra wrap bit.
//  - Top: eligibility mask, rotate-priority-encode-rotate arbiter, rr_ptr and ack registers,
//    sticky err.
// TESTING
//  1. Reset, then CPU2 drives RD_BROAD addr 0x100 one cycle -> mbus_ack_o=4'b0100 next cycle only;
//     head {2,4,0x100}; count=1.
//  2. All 4 CPUs WR_BROAD together from reset, ready=1 -> acks 0,1,2,3 on consecutive cycles;
//     heads in that order.
//  3. ready=0, 5 CPU requests with DEPTH=4 -> 4 acks, count=4, 5th CPU un-acked until one pop,
//     then acked the cycle after.
//  4. CPU1 issues RD (2) and WR (1) -> no ack, no push. CPU0 issues code 6 -> err_o=1 and stays 1
//     until rst.
//  5. Steady push+pop at full rate with ready=1 -> count constant, no drops, FIFO order across
//     pointer wrap.
//  6. rst asserted with count=3 and ack pending -> next cycle count=0, valid=0, ack=0, next grant
//     goes to CPU0.

Source files
------------

// File: rtl/mesi_isc_pkg.sv
// Shared main-bus constants and the broadcast-request queue entry for the MESI ISC.
// The arbiter and its request FIFO both import this package.
package mesi_isc_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int MBUS_CMD_WIDTH = 3;

  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_CMD_NOP      = 3'd0;
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_CMD_WR       = 3'd1;
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_CMD_RD       = 3'd2;
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_CMD_WR_BROAD = 3'd3;
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_CMD_RD_BROAD = 3'd4;

  typedef struct packed {
    logic [1:0]                id;
    logic [MBUS_CMD_WIDTH-1:0] cmd;
    logic [ADDR_WIDTH-1:0]     addr;
  } breq_entry_t;

  function automatic logic is_broad(input logic [MBUS_CMD_WIDTH-1:0] cmd);
    return (cmd == MBUS_CMD_WR_BROAD) || (cmd == MBUS_CMD_RD_BROAD);
  endfunction

  function automatic logic is_illegal(input logic [MBUS_CMD_WIDTH-1:0] cmd);
    return cmd > MBUS_CMD_RD_BROAD;
  endfunction

endpackage

// File: rtl/mesi_isc_breq_fifo.sv
// Show-ahead FIFO of broadcast requests. The pointers carry an extra wrap bit, so
// full and empty are told apart without a separate occupancy register.
module mesi_isc_breq_fifo
  import mesi_isc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  breq_entry_t push_data,
  input  logic        pop,
  output breq_entry_t pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  breq_entry_t mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mesi_isc_breq_arb.sv
// Round-robin arbiter over four CPU main-bus ports: acks one broadcast request per
// cycle and queues {id,cmd,addr} for the coherence-broadcast stage.
module mesi_isc_breq_arb
  import mesi_isc_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0][MBUS_CMD_WIDTH-1:0]       mbus_cmd_i,
  input  logic [3:0][ADDR_WIDTH-1:0]           mbus_addr_i,
  output logic [3:0]                           mbus_ack_o,
  output logic                                 breq_valid_o,
  input  logic                                 breq_ready_i,
  output logic [1:0]                           breq_id_o,
  output logic [MBUS_CMD_WIDTH-1:0]            breq_cmd_o,
  output logic [ADDR_WIDTH-1:0]                breq_addr_o,
  output logic [CW-1:0]                        fifo_count_o,
  output logic                                 err_o
);

  logic [1:0]  rr_ptr;
  logic [3:0]  eligible;
  logic [3:0]  illegal;
  logic        fifo_full;
  logic        fifo_empty;
  logic [2:0]  start;
  logic [7:0]  dbl;
  logic [3:0]  rot;
  logic [1:0]  offset;
  logic        grant_valid;
  logic [1:0]  grant_id;
  breq_entry_t push_data;
  breq_entry_t head;

  // A master still holding its cmd during its own ack cycle must not win again.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eligible[i] = is_broad(mbus_cmd_i[i]) && !mbus_ack_o[i] && !fifo_full;
      illegal[i]  = is_illegal(mbus_cmd_i[i]);
    end
  end

  // Rotate so the CPU after rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
  assign start = {1'b0, rr_ptr} + 3'd1;
  assign dbl   = {eligible, eligible};
  assign rot   = dbl[start +: 4];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) offset = 2'(k);
    end
  end

  assign grant_valid = |rot;
  assign grant_id    = start[1:0] + offset;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      mbus_ack_o <= '0;
      rr_ptr     <= 2'd3;
      err_o      <= 1'b0;
    end else begin
      mbus_ack_o <= grant_valid ? (4'b0001 << grant_id) : 4'b0000;
      if (grant_valid) rr_ptr <= grant_id;
      if (|illegal)    err_o  <= 1'b1;
    end
  end

  assign push_data = '{id: grant_id, cmd: mbus_cmd_i[grant_id], addr: mbus_addr_i[grant_id]};

  mesi_isc_breq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (push_data),
    .pop       (breq_ready_i),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_o)
  );

  assign breq_valid_o = ~fifo_empty;
  assign breq_id_o    = head.id;
  assign breq_cmd_o   = head.cmd;
  assign breq_addr_o  = head.addr;

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Self-checking bench for mesi_isc_breq_arb: directed scenarios with literal expectations
// plus randomized requesters, all compared every cycle against a queue-based model.
module tb_mesi_isc_breq_arb;
  import mesi_isc_pkg::*;

  localparam int DEPTH = 4;

  logic                           clk = 1'b0;
  logic                           rst = 1'b1;
  logic [3:0][MBUS_CMD_WIDTH-1:0] cmd = '0;
  logic [3:0][ADDR_WIDTH-1:0]     addr = '0;
  logic                           ready = 1'b0;
  logic [3:0]                     mbus_ack;
  logic                           breq_valid;
  logic [1:0]                     breq_id;
  logic [MBUS_CMD_WIDTH-1:0]      breq_cmd;
  logic [ADDR_WIDTH-1:0]          breq_addr;
  logic [2:0]                     fifo_count;
  logic                           err;

  mesi_isc_breq_arb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .mbus_cmd_i   (cmd),
    .mbus_addr_i  (addr),
    .mbus_ack_o   (mbus_ack),
    .breq_valid_o (breq_valid),
    .breq_ready_i (ready),
    .breq_id_o    (breq_id),
    .breq_cmd_o   (breq_cmd),
    .breq_addr_o  (breq_addr),
    .fifo_count_o (fifo_count),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending requests plus the last winner.
  typedef struct {
    int          id;
    int          cmd;
    logic [31:0] addr;
  } m_entry_t;

  m_entry_t m_q[$];
  int       m_rr  = 3;
  int       m_ack = -1;
  bit       m_err = 1'b0;

  task automatic model_step();
    bit full;
    int grant;
    if (rst) begin
      m_q.delete();
      m_rr  = 3;
      m_ack = -1;
      m_err = 1'b0;
      return;
    end
    full  = (m_q.size() == DEPTH);
    grant = -1;
    if (!full) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_rr + k) % 4;
        if (grant < 0 && (int'(cmd[i]) == 3 || int'(cmd[i]) == 4) && m_ack != i) grant = i;
      end
    end
    for (int i = 0; i < 4; i++) if (int'(cmd[i]) >= 5) m_err = 1'b1;
    if (ready && m_q.size() > 0) void'(m_q.pop_front());
    if (grant >= 0) begin
      m_q.push_back('{id: grant, cmd: int'(cmd[grant]), addr: addr[grant]});
      m_rr = grant;
    end
    m_ack = grant;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ack",   64'(mbus_ack), (m_ack < 0) ? 64'd0 : (64'd1 << m_ack));
      check("valid", 64'(breq_valid), 64'(m_q.size() > 0));
      check("count", 64'(fifo_count), 64'(m_q.size()));
      check("err",   64'(err), 64'(m_err));
      check("id",    64'(breq_id),   (m_q.size() > 0) ? 64'(m_q[0].id)   : 64'd0);
      check("cmd",   64'(breq_cmd),  (m_q.size() > 0) ? 64'(m_q[0].cmd)  : 64'd0);
      check("addr",  64'(breq_addr), (m_q.size() > 0) ? 64'(m_q[0].addr) : 64'd0);
    end
  end

  task automatic do_reset();
    rst   = 1'b1;
    cmd   = '0;
    addr  = '0;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic random_phase(input int cycles, input int rdy_pct);
    bit   [3:0] pend;
    logic [3:0] prev_ack;
    pend     = '0;
    prev_ack = '0;
    repeat (cycles) begin
      for (int i = 0; i < 4; i++) begin
        if (prev_ack[i]) begin
          cmd[i]  = MBUS_CMD_NOP;
          pend[i] = 1'b0;
        end else if (!pend[i]) begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 4) begin
            pend[i] = 1'b1;
            cmd[i]  = (r < 2) ? MBUS_CMD_WR_BROAD : MBUS_CMD_RD_BROAD;
            addr[i] = $urandom;
          end else if (r == 4) begin
            cmd[i] = ($urandom_range(0, 1) == 0) ? MBUS_CMD_WR : MBUS_CMD_RD;
          end else begin
            cmd[i] = MBUS_CMD_NOP;
          end
        end
      end
      ready    = ($urandom_range(0, 99) < rdy_pct);
      prev_ack = mbus_ack;
      tick();
    end
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;

    // Reset state
    check("rst_ack",   64'(mbus_ack), 64'd0);
    check("rst_valid", 64'(breq_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_err",   64'(err), 64'd0);

    // 1: single RD_BROAD from CPU2
    tick();
    cmd[2]  = MBUS_CMD_RD_BROAD;
    addr[2] = 32'h100;
    tick();
    check("t1_ack",   64'(mbus_ack), 64'h4);
    check("t1_count", 64'(fifo_count), 64'd1);
    check("t1_head",  64'({breq_id, breq_cmd, breq_addr}), 64'({2'd2, 3'd4, 32'h100}));
    cmd[2] = MBUS_CMD_NOP;
    tick();
    check("t1_ack_gone", 64'(mbus_ack), 64'd0);

    // 2: all four CPUs at once, ready=1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd[i]  = MBUS_CMD_WR_BROAD;
      addr[i] = 32'h10 * i;
    end
    ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t2_ack",  64'(mbus_ack), 64'd1 << c);
      check("t2_head", 64'(breq_id), 64'(c));
      if (c > 0) cmd[c-1] = MBUS_CMD_NOP;
    end
    cmd[3] = MBUS_CMD_NOP;
    tick();
    tick();

    // 3: fill the queue and hold off a fifth request until a pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd[i]  = MBUS_CMD_RD_BROAD;
      addr[i] = 32'h200 + i;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c > 0) cmd[c-1] = MBUS_CMD_NOP;
    end
    check("t3_full", 64'(fifo_count), 64'd4);
    cmd[0]  = MBUS_CMD_RD_BROAD;
    addr[0] = 32'h500;
    tick();
    cmd[3] = MBUS_CMD_NOP;
    check("t3_blocked", 64'(mbus_ack), 64'd0);
    tick();
    tick();
    check("t3_still_blocked", 64'(mbus_ack), 64'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t3_pop_no_grant", 64'(mbus_ack), 64'd0);
    check("t3_count3", 64'(fifo_count), 64'd3);
    tick();
    check("t3_late_ack", 64'(mbus_ack), 64'h1);
    check("t3_count4", 64'(fifo_count), 64'd4);
    cmd[0] = MBUS_CMD_NOP;
    tick();

    // 4: plain RD/WR are never acked; illegal code is sticky
    do_reset();
    cmd[1] = MBUS_CMD_RD;
    tick();
    tick();
    cmd[1] = MBUS_CMD_WR;
    tick();
    tick();
    check("t4_no_ack", 64'(mbus_ack), 64'd0);
    check("t4_no_push", 64'(fifo_count), 64'd0);
    check("t4_err0", 64'(err), 64'd0);
    cmd[1] = MBUS_CMD_NOP;
    cmd[0] = 3'd6;
    tick();
    cmd[0] = MBUS_CMD_NOP;
    check("t4_err_set", 64'(err), 64'd1);
    repeat (5) tick();
    check("t4_err_sticky", 64'(err), 64'd1);
    check("t4_illegal_not_queued", 64'(fifo_count), 64'd0);
    do_reset();
    check("t4_err_clear", 64'(err), 64'd0);

    // 5: randomized traffic, full-rate drain first so pointers wrap under push+pop
    random_phase(1500, 100);
    random_phase(1500, 50);
    random_phase(1500, 10);

    // 6: reset with three queued entries and an ack in flight
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd[i]  = MBUS_CMD_WR_BROAD;
      addr[i] = 32'h300 + i;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c > 0) cmd[c-1] = MBUS_CMD_NOP;
    end
    check("t6_pre_count", 64'(fifo_count), 64'd3);
    check("t6_pre_ack", 64'(mbus_ack), 64'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_count", 64'(fifo_count), 64'd0);
    check("t6_valid", 64'(breq_valid), 64'd0);
    check("t6_ack", 64'(mbus_ack), 64'd0);
    cmd[0]  = MBUS_CMD_RD_BROAD;
    addr[0] = 32'h600;
    cmd[2]  = MBUS_CMD_NOP;
    tick();
    check("t6_cpu0_first", 64'(mbus_ack), 64'h1);
    cmd = '0;
    tick();
    tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
